// File: rtl/operand_forward_unit_pkg.sv
// Shared types for the operand forwarding unit: tracker entry, select codes, select width.
// Pure definitions; no timing, no flow control.
package fwd_pkg;

  // Tracker rd field is sized for the widest supported register file; narrower AW zero-extends.
  localparam int RD_W_MAX = 8;

  typedef struct packed {
    logic                valid;
    logic [RD_W_MAX-1:0] rd;
    logic                is_load;
  } fwd_entry_t;

  localparam int SEL_RF         = 0;
  localparam int SEL_STAGE_BASE = 1;

  function automatic int fwd_sel_w(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/operand_forward_unit_if.sv
// EX-stage operand bundle between ID/EX, the forwarding unit and the ALU inputs.
// Combinational outputs; stall_o is the only backpressure, toward IF/ID/EX.
interface operand_forward_unit_if
  import fwd_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 2,
  parameter int AW         = 5
);
  localparam int SELW = fwd_sel_w(FWD_STAGES);

  logic                        advance_i;
  logic [AW-1:0]               ex_rd_i;
  logic                        ex_regwrite_i;
  logic                        ex_is_load_i;
  logic [NUM_SRC*AW-1:0]       ex_rs_i;
  logic [NUM_SRC*WIDTH-1:0]    ex_rf_data_i;
  logic [FWD_STAGES*WIDTH-1:0] stage_data_i;
  logic                        flush_i;
  logic [NUM_SRC*WIDTH-1:0]    src_o;
  logic [NUM_SRC*SELW-1:0]     fwd_sel_o;
  logic                        stall_o;
  logic [31:0]                 stall_count_o;

  modport master (
    output advance_i, ex_rd_i, ex_regwrite_i, ex_is_load_i, ex_rs_i,
           ex_rf_data_i, stage_data_i, flush_i,
    input  src_o, fwd_sel_o, stall_o, stall_count_o
  );

  modport slave (
    input  advance_i, ex_rd_i, ex_regwrite_i, ex_is_load_i, ex_rs_i,
           ex_rf_data_i, stage_data_i, flush_i,
    output src_o, fwd_sel_o, stall_o, stall_count_o
  );
endinterface

// File: rtl/operand_forward_unit_operand_sel.sv
// Youngest-producer priority match for one EX source operand; purely combinational.
// Flags a load hazard instead of selecting when the winning producer's data is not ready yet.
module fwd_operand_sel
  import fwd_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int FWD_STAGES       = 2,
  parameter int AW               = 5,
  parameter int LOAD_READY_STAGE = 1,
  parameter int SELW             = 2
) (
  input  logic [AW-1:0]               rs,
  input  logic [WIDTH-1:0]            rf_data,
  input  fwd_entry_t                  entries [FWD_STAGES],
  input  logic [FWD_STAGES*WIDTH-1:0] stage_data,
  output logic [SELW-1:0]             sel,
  output logic [WIDTH-1:0]            data,
  output logic                        load_hazard
);
  logic [RD_W_MAX-1:0] rs_ext;
  logic                found;

  assign rs_ext = RD_W_MAX'(rs);

  always_comb begin
    sel         = SELW'(SEL_RF);
    data        = rf_data;
    load_hazard = 1'b0;
    found       = 1'b0;
    for (int k = 0; k < FWD_STAGES; k++) begin
      if (!found && entries[k].valid && entries[k].rd == rs_ext && entries[k].rd != '0) begin
        found = 1'b1;
        // Load result not yet available: stall and leave the select parked on the register file.
        if (entries[k].is_load && k < LOAD_READY_STAGE) begin
          load_hazard = 1'b1;
        end else begin
          sel  = SELW'(k + SEL_STAGE_BASE);
          data = stage_data[k*WIDTH +: WIDTH];
        end
      end
    end
  end
endmodule

// File: rtl/operand_forward_unit.sv
// Execute-stage operand forwarding with an in-flight destination tracker and load-use stall.
// Zero-cycle select/data; stall_o holds IF/ID/EX and inserts a bubble into the tracker.
module operand_forward_unit
  import fwd_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int NUM_SRC          = 2,
  parameter int FWD_STAGES       = 2,
  parameter int AW               = 5,
  parameter int LOAD_READY_STAGE = 1,
  parameter int SELW             = fwd_sel_w(FWD_STAGES)
) (
  input  logic                  clk,
  input  logic                  rst,
  operand_forward_unit_if.slave bus
);
  fwd_entry_t                 trk [FWD_STAGES];
  logic [NUM_SRC-1:0]         hazard;
  logic [NUM_SRC*WIDTH-1:0]   src_flat;
  logic [NUM_SRC*SELW-1:0]    sel_flat;
  logic                       stall;
  logic [31:0]                stall_count;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_operand_sel #(
      .WIDTH            (WIDTH),
      .FWD_STAGES       (FWD_STAGES),
      .AW               (AW),
      .LOAD_READY_STAGE (LOAD_READY_STAGE),
      .SELW             (SELW)
    ) u_sel (
      .rs          (bus.ex_rs_i[i*AW +: AW]),
      .rf_data     (bus.ex_rf_data_i[i*WIDTH +: WIDTH]),
      .entries     (trk),
      .stage_data  (bus.stage_data_i),
      .sel         (sel_flat[i*SELW +: SELW]),
      .data        (src_flat[i*WIDTH +: WIDTH]),
      .load_hazard (hazard[i])
    );
  end

  assign stall             = |hazard;
  assign bus.stall_o       = stall;
  assign bus.src_o         = src_flat;
  assign bus.fwd_sel_o     = sel_flat;
  assign bus.stall_count_o = stall_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < FWD_STAGES; k++) trk[k] <= '0;
      stall_count <= '0;
    end else if (bus.advance_i) begin
      for (int k = 1; k < FWD_STAGES; k++) trk[k] <= trk[k-1];
      // Stalled or flushed EX instructions enter the tracker as bubbles.
      trk[0] <= '{valid:   bus.ex_regwrite_i & ~bus.flush_i & ~stall,
                  rd:      RD_W_MAX'(bus.ex_rd_i),
                  is_load: bus.ex_is_load_i};
      if (stall && stall_count != 32'hFFFF_FFFF) stall_count <= stall_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_operand_forward_unit.sv
// Directed bench for operand_forward_unit: forwarding priority, x0, flush, load-use stall, reset.
module tb_operand_forward_unit;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  operand_forward_unit_if #(.WIDTH(32), .NUM_SRC(2), .FWD_STAGES(2), .AW(5)) bus ();

  operand_forward_unit #(
    .WIDTH(32), .NUM_SRC(2), .FWD_STAGES(2), .AW(5), .LOAD_READY_STAGE(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic [4:0] rd, input logic wr, input logic ld,
                          input logic [4:0] rs1, input logic [4:0] rs0);
    bus.ex_rd_i       = rd;
    bus.ex_regwrite_i = wr;
    bus.ex_is_load_i  = ld;
    bus.ex_rs_i       = {rs1, rs0};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.advance_i    = 1'b0;
    bus.flush_i      = 1'b0;
    bus.stage_data_i = {32'h0000_0BBB, 32'h0000_0AAA};
    drive_ex(5'd0, 1'b0, 1'b0, 5'd2, 5'd1);
    bus.ex_rf_data_i = {32'h22, 32'h11};
    do_reset();
    checks++; if (bus.fwd_sel_o !== 4'b0000) begin errors++; $display("FAIL reset_sel got %h want 0", bus.fwd_sel_o); end
    checks++; if (bus.src_o !== {32'h22, 32'h11}) begin errors++; $display("FAIL reset_src got %h want %h", bus.src_o, {32'h22, 32'h11}); end
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", bus.stall_o); end
    checks++; if (bus.stall_count_o !== 32'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.stall_count_o); end
  endtask

  task automatic test_back_to_back();
    bus.advance_i = 1'b1;
    drive_ex(5'd5, 1'b1, 1'b0, 5'd2, 5'd1);   // ADD x5
    tick();
    drive_ex(5'd8, 1'b1, 1'b0, 5'd6, 5'd5);   // SUB x8, x5, x6
    bus.ex_rf_data_i = {32'h66, 32'h55};
    bus.stage_data_i = {32'h0, 32'hDEAD_BEEF};
    #1;
    checks++; if (bus.fwd_sel_o[1:0] !== 2'd1) begin errors++; $display("FAIL b2b_sel0 got %0d want 1", bus.fwd_sel_o[1:0]); end
    checks++; if (bus.src_o[31:0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_src0 got %h want deadbeef", bus.src_o[31:0]); end
    checks++; if (bus.src_o[63:32] !== 32'h66) begin errors++; $display("FAIL b2b_src1 got %h want 66", bus.src_o[63:32]); end
    tick();
    drive_ex(5'd9, 1'b1, 1'b0, 5'd5, 5'd1);   // consumer of x5, producer now in stage 1
    bus.stage_data_i = {32'hDEAD_BEEF, 32'h1234_5678};
    #1;
    checks++; if (bus.fwd_sel_o[3:2] !== 2'd2) begin errors++; $display("FAIL b2b_sel1_stage1 got %0d want 2", bus.fwd_sel_o[3:2]); end
    checks++; if (bus.src_o[63:32] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_src1_stage1 got %h want deadbeef", bus.src_o[63:32]); end
    checks++; if (bus.fwd_sel_o[1:0] !== 2'd0) begin errors++; $display("FAIL b2b_sel0_none got %0d want 0", bus.fwd_sel_o[1:0]); end
  endtask

  task automatic test_youngest();
    do_reset();
    bus.advance_i = 1'b1;
    drive_ex(5'd7, 1'b1, 1'b0, 5'd0, 5'd0);
    tick();
    tick();
    drive_ex(5'd0, 1'b0, 1'b0, 5'd0, 5'd7);
    bus.stage_data_i = {32'hB, 32'hA};
    #1;
    checks++; if (bus.fwd_sel_o[1:0] !== 2'd1) begin errors++; $display("FAIL youngest_sel got %0d want 1", bus.fwd_sel_o[1:0]); end
    checks++; if (bus.src_o[31:0] !== 32'hA) begin errors++; $display("FAIL youngest_src got %h want a", bus.src_o[31:0]); end
  endtask

  task automatic test_load_use();
    do_reset();
    bus.advance_i = 1'b1;
    drive_ex(5'd3, 1'b1, 1'b1, 5'd0, 5'd0);   // LW x3
    tick();
    drive_ex(5'd4, 1'b1, 1'b0, 5'd0, 5'd3);   // ADD x4, x3
    bus.ex_rf_data_i = {32'h0, 32'h33};
    bus.stage_data_i = {32'hCAFE_0001, 32'hBAD0_0000};
    #1;
    checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL lu_stall got %b want 1", bus.stall_o); end
    checks++; if (bus.fwd_sel_o[1:0] !== 2'd0) begin errors++; $display("FAIL lu_sel_stalled got %0d want 0", bus.fwd_sel_o[1:0]); end
    checks++; if (bus.stall_count_o !== 32'd0) begin errors++; $display("FAIL lu_count_before got %0d want 0", bus.stall_count_o); end
    tick();
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL lu_stall_clear got %b want 0", bus.stall_o); end
    checks++; if (bus.stall_count_o !== 32'd1) begin errors++; $display("FAIL lu_count_after got %0d want 1", bus.stall_count_o); end
    checks++; if (bus.fwd_sel_o[1:0] !== 2'd2) begin errors++; $display("FAIL lu_sel_ready got %0d want 2", bus.fwd_sel_o[1:0]); end
    checks++; if (bus.src_o[31:0] !== 32'hCAFE_0001) begin errors++; $display("FAIL lu_src_ready got %h want cafe0001", bus.src_o[31:0]); end
    tick();
    checks++; if (bus.stall_count_o !== 32'd1) begin errors++; $display("FAIL lu_count_hold got %0d want 1", bus.stall_count_o); end
  endtask

  task automatic test_x0_flush();
    do_reset();
    bus.advance_i = 1'b1;
    drive_ex(5'd0, 1'b1, 1'b0, 5'd0, 5'd0);   // producer writes x0
    tick();
    drive_ex(5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    bus.ex_rf_data_i = {32'h0, 32'h0};
    bus.stage_data_i = {32'h0, 32'h55};
    #1;
    checks++; if (bus.fwd_sel_o[1:0] !== 2'd0) begin errors++; $display("FAIL x0_sel got %0d want 0", bus.fwd_sel_o[1:0]); end
    checks++; if (bus.src_o[31:0] !== 32'h0) begin errors++; $display("FAIL x0_src got %h want 0", bus.src_o[31:0]); end
    drive_ex(5'd9, 1'b1, 1'b0, 5'd0, 5'd0);   // flushed producer of x9
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    drive_ex(5'd0, 1'b0, 1'b0, 5'd9, 5'd0);
    bus.ex_rf_data_i = {32'h99, 32'h0};
    bus.stage_data_i = {32'h0, 32'h77};
    #1;
    checks++; if (bus.fwd_sel_o[3:2] !== 2'd0) begin errors++; $display("FAIL flush_sel got %0d want 0", bus.fwd_sel_o[3:2]); end
    checks++; if (bus.src_o[63:32] !== 32'h99) begin errors++; $display("FAIL flush_src got %h want 99", bus.src_o[63:32]); end
  endtask

  task automatic test_stall_hold_reset();
    do_reset();
    bus.advance_i = 1'b1;
    drive_ex(5'd3, 1'b1, 1'b1, 5'd0, 5'd0);   // LW x3
    tick();
    drive_ex(5'd4, 1'b1, 1'b0, 5'd0, 5'd3);   // stalls once
    tick();
    drive_ex(5'd10, 1'b1, 1'b1, 5'd0, 5'd0);  // LW x10
    tick();
    drive_ex(5'd11, 1'b1, 1'b0, 5'd0, 5'd10); // consumer of x10 -> stall
    bus.advance_i = 1'b0;
    #1;
    checks++; if (bus.stall_count_o !== 32'd1) begin errors++; $display("FAIL hold_count_start got %0d want 1", bus.stall_count_o); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL hold_stall cyc %0d got %b want 1", c, bus.stall_o); end
      checks++; if (bus.stall_count_o !== 32'd1) begin errors++; $display("FAIL hold_count cyc %0d got %0d want 1", c, bus.stall_count_o); end
    end
    bus.advance_i = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", bus.stall_o); end
    checks++; if (bus.stall_count_o !== 32'd0) begin errors++; $display("FAIL rst_count got %0d want 0", bus.stall_count_o); end
    checks++; if (bus.fwd_sel_o !== 4'b0000) begin errors++; $display("FAIL rst_sel got %h want 0", bus.fwd_sel_o); end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_back_to_back();
    test_youngest();
    test_load_use();
    test_x0_flush();
    test_stall_hold_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "bench did not terminate");
  end
endmodule

// File: doc/operand_forward_unit.md
Name: operand_forward_unit

Overview:
- Parametrised successor to the execute-stage operand forwarding mux, for NUM_SRC source operands and FWD_STAGES downstream result stages.
- Owns an internal scoreboard: a shift register tracking the destination register of each in-flight older instruction (stage 0 = MEM, stage 1 = WB, ...).
- Each cycle it selects the youngest valid producer for every EX-stage source. It detects load-use hazards, inserts bubbles into its own tracker while stalling, and counts stall cycles.
- Sits between the ID/EX register outputs and the ALU operand inputs.

Parameters:
- WIDTH, 32, data width.
- NUM_SRC, 2, number of EX source operands (2 = rs1/rs2, 3 for fused ops).
- FWD_STAGES, 2, number of tracked downstream stages (>=1).
- AW, 5, register address width.
- LOAD_READY_STAGE, 1, first tracker stage whose stage_data_i holds valid load data (0..FWD_STAGES-1).
- SELW, $clog2(FWD_STAGES+1), width of each select code.

Ports:
- clk, in, 1, clock (all state on rising edge).
- rst, in, 1, synchronous active-high reset.
- advance_i, in, 1, pipeline advances this cycle.
- ex_rd_i, in, AW, destination register of the instruction in EX.
- ex_regwrite_i, in, 1, EX instruction writes the register file.
- ex_is_load_i, in, 1, EX instruction is a load.
- ex_rs_i, in, NUM_SRC*AW, EX source addresses (operand i at [i*AW +: AW]).
- ex_rf_data_i, in, NUM_SRC*WIDTH, register-file values latched into ID/EX.
- stage_data_i, in, FWD_STAGES*WIDTH, result value present in tracker stage k.
- flush_i, in, 1, kill the EX instruction (it is not pushed into the tracker).
- src_o, out, NUM_SRC*WIDTH, forwarded operands.
- fwd_sel_o, out, NUM_SRC*SELW, select per operand: 0 = register file, k+1 = stage k.
- stall_o, out, 1, load-use stall request (hold IF/ID/EX).
- stall_count_o, out, 32, saturating count of stall cycles.

Behaviour:
- Tracker entry fields: valid, rd, is_load. Entry k sits in stage k.
- Reset: all entries invalid; stall_count_o = 0. Consequently stall_o = 0, every fwd_sel_o = 0, and src_o = ex_rf_data_i.
- Reset takes priority over advance_i and flush_i, including mid-stall.
- Match for operand i at stage k: entry valid AND rd == ex_rs[i] AND rd != 0. Register x0 is never forwarded.
- Priority: the lowest matching k (youngest) wins. fwd_sel = k+1 and src = stage_data_i[k]. With no match, fwd_sel = 0 and src = ex_rf_data[i].
- Load-use: stall_o = 1 if any operand's winning match is an is_load entry at stage k < LOAD_READY_STAGE. While stalling, that operand's fwd_sel is 0 (its value is don't-care).
- Decisions are purely combinational from current state and inputs; there is zero-cycle latency to src_o and fwd_sel_o.
- Tracker update at posedge when advance_i = 1:
  - Entries shift k -> k+1; the entry in the last stage is discarded.
  - Entry 0 is loaded with {ex_regwrite_i & ~flush_i & ~stall_o, ex_rd_i, ex_is_load_i}.
  - A stalled or flushed EX instruction therefore becomes a bubble. On stall the EX instruction is held and re-evaluated next cycle against the shifted tracker.
- When advance_i = 0, the tracker holds and the stall counter does not increment.
- stall_count_o increments at posedge when stall_o & advance_i, and saturates at 0xFFFFFFFF.
- With LOAD_READY_STAGE = 0 no stalls ever occur.
- With FWD_STAGES = 1 only stage 0 is tracked. Older producers rely on write-first register-file behaviour.
- No $stop and no X-producing default branches; unreachable select codes drive ex_rf_data.

Decomposition:
- Package fwd_pkg holds:
  - the tracker entry struct typedef (valid, rd, is_load);
  - the select encoding constants SEL_RF = 0 and SEL_STAGE_BASE = 1;
  - a function fwd_sel_w(stages) returning $clog2(stages+1).
- Sub-module fwd_operand_sel is instantiated NUM_SRC times. It is a combinational priority match across the tracker for one operand and outputs the select, the value and a load_hazard flag.
- The top level holds the tracker shift register, the stall OR-reduction and the counter.

Test Plan:
- Reset, then apply ex_rs = {x2, x1} with rf data 0x11/0x22 and all stages empty -> sel = 0/0, src = rf data, stall_o = 0.
- Back-to-back ADD x5 followed by SUB using x5, with stage_data[0] = 0xDEAD_BEEF -> sel = 1, src = 0xDEADBEEF. Next cycle (producer in stage 1, stage_data[1] = 0xDEADBEEF) -> sel = 2.
- Both stages write x7 (stage0 = 0xA, stage1 = 0xB), consumer reads x7 -> youngest wins: sel = 1, src = 0xA.
- LW x3 followed immediately by ADD using x3 (LOAD_READY_STAGE = 1):
  - stall_o = 1 for exactly one cycle and stall_count_o goes 0 -> 1;
  - the next cycle gives sel = 2 with src = stage_data[1].
- A producer writing x0 with value 0x55 and a consumer reading x0 -> sel = 0, src = rf data (0). A flushed producer writing x9 -> no forward next cycle.
- Assert rst during a stall -> next cycle all entries invalid, stall_o = 0, stall_count_o = 0. Also hold advance_i = 0 for 3 cycles during a stall -> counter unchanged.
